// File: rtl/taillight_pkg.sv
// Shared types and defaults for the sequential tail-light controller.
package taillight_pkg;

  localparam int LAMPS_DEF    = 3;
  localparam int TICK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LSEQ    = 3'd1,
    RSEQ    = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_HAZ   = 2'd1,
    REQ_LEFT  = 2'd2,
    REQ_RIGHT = 2'd3
  } req_e;

  // Both turn stalks at once behave as a hazard request.
  function automatic req_e req_decode(
    input logic hazard,
    input logic left,
    input logic right
  );
    req_e r;
    if (hazard || (left && right)) r = REQ_HAZ;
    else if (left)                 r = REQ_LEFT;
    else if (right)                r = REQ_RIGHT;
    else                           r = REQ_NONE;
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle animation tick.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/taillight_ctrl.sv
// Turn / hazard / brake tail-light sequencer.
module taillight_ctrl
  import taillight_pkg::*;
#(
  parameter int LAMPS    = LAMPS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] L,
  output logic [LAMPS-1:0] R,
  output logic             active
);

  localparam int KW = $clog2(LAMPS + 1);
  localparam logic [KW-1:0] K_ONE = KW'(1);
  localparam logic [KW-1:0] K_MAX = KW'(LAMPS);

  logic            tick;
  req_e            req;
  state_e          state_q;
  state_e          state_d;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   k_d;
  logic [LAMPS-1:0] therm;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .Reset_n(Reset_n),
    .tick   (tick)
  );

  assign req = req_decode(hazard, left, right);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          k_d = K_ONE;
          unique case (req)
            REQ_HAZ:   state_d = HAZ_ON;
            REQ_LEFT:  state_d = LSEQ;
            REQ_RIGHT: state_d = RSEQ;
            default:   state_d = IDLE;
          endcase
        end
        LSEQ: begin
          if (req == REQ_HAZ) begin
            state_d = HAZ_ON;
            k_d     = K_ONE;
          end else if (req == REQ_LEFT && k_q < K_MAX) begin
            k_d = k_q + K_ONE;
          end else begin
            state_d = IDLE;
            k_d     = K_ONE;
          end
        end
        RSEQ: begin
          if (req == REQ_HAZ) begin
            state_d = HAZ_ON;
            k_d     = K_ONE;
          end else if (req == REQ_RIGHT && k_q < K_MAX) begin
            k_d = k_q + K_ONE;
          end else begin
            state_d = IDLE;
            k_d     = K_ONE;
          end
        end
        HAZ_ON:  state_d = (req == REQ_HAZ) ? HAZ_OFF : IDLE;
        HAZ_OFF: state_d = (req == REQ_HAZ) ? HAZ_ON  : IDLE;
        default: begin
          state_d = IDLE;
          k_d     = K_ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      k_q     <= K_ONE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Low k bits set; k == LAMPS shifts everything out, giving all ones.
  assign therm = ~({LAMPS{1'b1}} << k_q);

  always_comb begin
    L      = '0;
    R      = '0;
    active = (state_q != IDLE);
    unique case (state_q)
      LSEQ: begin
        L = therm;
        R = brake ? '1 : '0;
      end
      RSEQ: begin
        R = therm;
        L = brake ? '1 : '0;
      end
      HAZ_ON: begin
        L = '1;
        R = '1;
      end
      default: begin
        L = brake ? '1 : '0;
        R = brake ? '1 : '0;
      end
    endcase
  end

endmodule
